// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: one reservation station wins per cycle
// and its result is latched into a one-entry output register. Optional: CDB_ARB_PERF_CNT_EN.
module cdb_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned ROB_IDX_LEN    = 6,
  parameter int unsigned ROB_EXCEPT_LEN = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ*ROB_IDX_LEN-1:0]      req_idx_i,
  input  logic [N_REQ*XLEN-1:0]             req_data_i,
  input  logic [N_REQ-1:0]                  req_except_raised_i,
  input  logic [N_REQ*ROB_EXCEPT_LEN-1:0]   req_except_code_i,
  input  logic                              rob_ready_i,
  output logic                              cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0]            cdb_idx_o,
  output logic [XLEN-1:0]                   cdb_data_o,
  output logic                              cdb_except_raised_o,
  output logic [ROB_EXCEPT_LEN-1:0]         cdb_except_o
`ifdef CDB_ARB_PERF_CNT_EN
  ,
  output logic [N_REQ*32-1:0]               perf_grant_cnt_o,
  output logic [31:0]                       perf_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]          prio_ptr_r;
  logic [PTR_W-1:0]          prio_ptr_nxt_s;
  logic [PTR_W-1:0]          win_s;
  logic [PTR_W-1:0]          cand_s;
  logic [N_REQ-1:0]          grant_s;
  logic                      grant_any_s;
  logic                      out_free_s;
  logic                      cdb_valid_r;
  logic [ROB_IDX_LEN-1:0]    cdb_idx_r;
  logic [XLEN-1:0]           cdb_data_r;
  logic                      cdb_except_raised_r;
  logic [ROB_EXCEPT_LEN-1:0] cdb_except_r;
  logic [ROB_IDX_LEN-1:0]    sel_idx_s;
  logic [XLEN-1:0]           sel_data_s;
  logic                      sel_except_raised_s;
  logic [ROB_EXCEPT_LEN-1:0] sel_except_s;

  // The output slot can take a new beat when it is empty or being consumed this cycle.
  assign out_free_s = !cdb_valid_r || rob_ready_i;

  // Round-robin search starting at the priority pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_s     = '0;
    win_s       = '0;
    cand_s      = '0;
    grant_any_s = 1'b0;
    if (out_free_s && !flush_i && !rst_i) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        cand_s = PTR_W'((int'(prio_ptr_r) + i) % int'(N_REQ));
        if (!grant_any_s && req_valid_i[cand_s]) begin
          grant_any_s     = 1'b1;
          win_s           = cand_s;
          grant_s[cand_s] = 1'b1;
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_comb begin
    prio_ptr_nxt_s = prio_ptr_r;
    if (grant_any_s) begin
      if (32'(win_s) == (N_REQ - 32'd1)) begin
        prio_ptr_nxt_s = '0;
      end else begin
        prio_ptr_nxt_s = win_s + PTR_W'(1);
      end
    end else begin
      prio_ptr_nxt_s = prio_ptr_r;
    end
  end

  // One-hot payload mux driven by the grant vector.
  always_comb begin
    sel_idx_s           = '0;
    sel_data_s          = '0;
    sel_except_raised_s = 1'b0;
    sel_except_s        = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_s[i]) begin
        sel_idx_s           = req_idx_i[i*ROB_IDX_LEN +: ROB_IDX_LEN];
        sel_data_s          = req_data_i[i*XLEN +: XLEN];
        sel_except_raised_s = req_except_raised_i[i];
        sel_except_s        = req_except_code_i[i*ROB_EXCEPT_LEN +: ROB_EXCEPT_LEN];
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // Output beat register and priority pointer; flush drops the in-flight beat only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cdb_valid_r         <= 1'b0;
      cdb_idx_r           <= '0;
      cdb_data_r          <= '0;
      cdb_except_raised_r <= 1'b0;
      cdb_except_r        <= '0;
      prio_ptr_r          <= '0;
    end else begin
      prio_ptr_r <= prio_ptr_nxt_s;
      if (flush_i) begin
        cdb_valid_r <= 1'b0;
      end else if (grant_any_s) begin
        cdb_valid_r         <= 1'b1;
        cdb_idx_r           <= sel_idx_s;
        cdb_data_r          <= sel_data_s;
        cdb_except_raised_r <= sel_except_raised_s;
        cdb_except_r        <= sel_except_s;
      end else if (rob_ready_i) begin
        cdb_valid_r <= 1'b0;
      end else begin
        cdb_valid_r <= cdb_valid_r;
      end
    end
  end

  assign req_ready_o         = grant_s;
  assign cdb_valid_o         = cdb_valid_r;
  assign cdb_idx_o           = cdb_idx_r;
  assign cdb_data_o          = cdb_data_r;
  assign cdb_except_raised_o = cdb_except_raised_r;
  assign cdb_except_o        = cdb_except_r;

`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_r [N_REQ];
  logic [31:0] stall_cnt_r;

  // Free-running wrapping counters; flush does not clear them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        grant_cnt_r[i] <= 32'd0;
      end
      stall_cnt_r <= 32'd0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (grant_s[i]) begin
          grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
        end else begin
          grant_cnt_r[i] <= grant_cnt_r[i];
        end
      end
      if (cdb_valid_r && !rob_ready_i) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_perf
    assign perf_grant_cnt_o[g*32 +: 32] = grant_cnt_r[g];
  end
  assign perf_stall_cnt_o = stall_cnt_r;
`endif

endmodule
